dot_product_engine: RTL and testbench

//   Runtime-length dot-product engine for the dotProduct subsystem. Holds operand vectors A/B in

---
 rtl/dot_product_engine_if.sv | 32 +++
 rtl/dot_product_engine.sv | 121 ++++++++++++
 tb/tb_dot_product_engine.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dot_product_engine_if.sv
// dot_product_engine_if: operand write, control/status and result read bus of the dot-product engine
interface dot_product_engine_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_LEN        = 16,
    parameter int RES_DEPTH      = 16,
    parameter int ADDR_WIDTH     = $clog2(MAX_LEN),
    parameter int RESULT_WIDTH   = 2*DATA_WIDTH+$clog2(MAX_LEN),
    parameter int RES_ADDR_WIDTH = $clog2(RES_DEPTH)
);
    logic                      wr_en;
    logic [ADDR_WIDTH-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0]     wr_data_a;
    logic [DATA_WIDTH-1:0]     wr_data_b;
    logic                      start;
    logic [ADDR_WIDTH:0]       vec_len;
    logic                      signed_mode;
    logic                      busy;
    logic                      done;
    logic                      err;
    logic [RES_ADDR_WIDTH:0]   res_count;
    logic                      rd_en;
    logic [RES_ADDR_WIDTH-1:0] rd_addr;
    logic [RESULT_WIDTH-1:0]   rd_data;
    modport master (
        output wr_en, wr_addr, wr_data_a, wr_data_b, start, vec_len, signed_mode, rd_en, rd_addr,
        input  busy, done, err, res_count, rd_data
    );
    modport slave (
        input  wr_en, wr_addr, wr_data_a, wr_data_b, start, vec_len, signed_mode, rd_en, rd_addr,
        output busy, done, err, res_count, rd_data
    );
endinterface

// File: rtl/dot_product_engine.sv
// dot_product_engine: runtime-length LANES-wide signed/unsigned dot product with circular result RAM
module dot_product_engine #(
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_LEN        = 16,
    parameter int LANES          = 2,
    parameter int RES_DEPTH      = 16,
    parameter int ADDR_WIDTH     = $clog2(MAX_LEN),
    parameter int RESULT_WIDTH   = 2*DATA_WIDTH+$clog2(MAX_LEN),
    parameter int RES_ADDR_WIDTH = $clog2(RES_DEPTH)
) (
    input logic clk,
    input logic rst,
    dot_product_engine_if.slave bus
);
    localparam int IW = ADDR_WIDTH + 2;
    localparam int PW = 2*DATA_WIDTH + 2;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, STORE} state_t;
    state_t r_state, w_next;
    logic [DATA_WIDTH-1:0]     r_ram_a [MAX_LEN];
    logic [DATA_WIDTH-1:0]     r_ram_b [MAX_LEN];
    logic [RESULT_WIDTH-1:0]   r_res_ram [RES_DEPTH];
    logic [ADDR_WIDTH:0]       r_len;
    logic                      r_signed;
    logic [IW-1:0]             r_base;
    logic                      r_dcnt;
    logic [DATA_WIDTH:0]       r_opa [LANES];
    logic [DATA_WIDTH:0]       r_opb [LANES];
    logic signed [PW-1:0]      r_prod [LANES];
    logic [RESULT_WIDTH-1:0]   r_acc;
    logic [RES_ADDR_WIDTH-1:0] r_wr_ptr;
    logic [RES_ADDR_WIDTH:0]   r_count;
    logic                      r_done;
    logic                      r_err;
    logic [RESULT_WIDTH-1:0]   r_rd_data;
    logic [IW-1:0]             w_idx [LANES];
    logic [DATA_WIDTH:0]       w_ea [LANES];
    logic [DATA_WIDTH:0]       w_eb [LANES];
    logic [RESULT_WIDTH-1:0]   w_sum;
    logic                      w_len_ok;
    logic                      w_go;
    logic                      w_last;
    assign w_len_ok = bus.vec_len != '0 && bus.vec_len <= (ADDR_WIDTH+1)'(MAX_LEN);
    assign w_go     = r_state == IDLE && bus.start && w_len_ok;
    assign w_last   = (r_base + IW'(LANES)) >= IW'(r_len);
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = w_go ? FETCH : IDLE;
            FETCH:   w_next = w_last ? DRAIN : FETCH;
            DRAIN:   w_next = r_dcnt ? STORE : DRAIN;
            default: w_next = IDLE;
        endcase
    end
    // Lanes past vec_len (or outside FETCH) feed zeros, so the downstream stages can run freely.
    always_comb begin
        w_sum = r_acc;
        for (int l = 0; l < LANES; l++) begin
            w_idx[l] = r_base + IW'(l);
            w_ea[l]  = (r_state == FETCH && w_idx[l] < IW'(r_len)) ?
                       {r_signed & r_ram_a[w_idx[l][ADDR_WIDTH-1:0]][DATA_WIDTH-1], r_ram_a[w_idx[l][ADDR_WIDTH-1:0]]} : '0;
            w_eb[l]  = (r_state == FETCH && w_idx[l] < IW'(r_len)) ?
                       {r_signed & r_ram_b[w_idx[l][ADDR_WIDTH-1:0]][DATA_WIDTH-1], r_ram_b[w_idx[l][ADDR_WIDTH-1:0]]} : '0;
            w_sum    = w_sum + RESULT_WIDTH'(r_prod[l]);
        end
    end
    always_ff @(posedge clk) begin
        if (bus.wr_en && r_state == IDLE) begin
            r_ram_a[bus.wr_addr] <= bus.wr_data_a;
            r_ram_b[bus.wr_addr] <= bus.wr_data_b;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && r_state == STORE) r_res_ram[r_wr_ptr] <= r_acc;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_len     <= '0;
            r_signed  <= 1'b0;
            r_base    <= '0;
            r_dcnt    <= 1'b0;
            r_acc     <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rd_data <= '0;
            for (int l = 0; l < LANES; l++) begin
                r_opa[l]  <= '0;
                r_opb[l]  <= '0;
                r_prod[l] <= '0;
            end
        end else begin
            r_state <= w_next;
            r_done  <= r_state == STORE;
            r_err   <= r_state == IDLE && bus.start && !w_len_ok;
            r_dcnt  <= r_state == DRAIN ? !r_dcnt : 1'b0;
            r_base  <= w_go ? '0 : (r_state == FETCH ? r_base + IW'(LANES) : r_base);
            r_acc   <= w_go ? '0 : w_sum;
            if (w_go) begin
                r_len    <= bus.vec_len;
                r_signed <= bus.signed_mode;
            end
            for (int l = 0; l < LANES; l++) begin
                r_opa[l]  <= w_ea[l];
                r_opb[l]  <= w_eb[l];
                r_prod[l] <= PW'($signed(r_opa[l])) * PW'($signed(r_opb[l]));
            end
            if (r_state == STORE) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_count  <= r_count + (RES_ADDR_WIDTH+1)'(r_count != (RES_ADDR_WIDTH+1)'(RES_DEPTH));
            end
            if (bus.rd_en) r_rd_data <= r_res_ram[bus.rd_addr];
        end
    end
    assign bus.busy      = r_state != IDLE;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.res_count = r_count;
    assign bus.rd_data   = r_rd_data;
endmodule

// File: tb/tb_dot_product_engine.sv
// tb_dot_product_engine: directed self-checking bench for dot_product_engine
module tb_dot_product_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;
    int   lat;
    always #5 clk = ~clk;
    dot_product_engine_if bus();
    dot_product_engine dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic write_op(input int addr, input int a, input int b);
        bus.wr_en = 1'b1;
        bus.wr_addr = 4'(addr);
        bus.wr_data_a = 8'(a);
        bus.wr_data_b = 8'(b);
        step();
        bus.wr_en = 1'b0;
    endtask
    task automatic rd_chk(input string tag, input int addr, input logic [31:0] exp);
        bus.rd_en = 1'b1;
        bus.rd_addr = 4'(addr);
        step();
        bus.rd_en = 1'b0;
        chk(tag, 32'(bus.rd_data), exp);
    endtask
    task automatic wait_done(input string tag, input int exp_lat);
        while (!bus.done && lat < 40) begin
            step();
            lat++;
        end
        chk(tag, 32'(lat), 32'(exp_lat));
        chk("busy_at_done", 32'(bus.busy), 32'd0);
    endtask
    task automatic run(input string tag, input int len, input logic sgn, input int exp_lat);
        bus.start = 1'b1;
        bus.vec_len = 5'(len);
        bus.signed_mode = sgn;
        step();
        bus.start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        lat = 0;
        wait_done(tag, exp_lat);
    endtask
    task automatic bad_len(input string tag, input int len);
        bus.start = 1'b1;
        bus.vec_len = 5'(len);
        step();
        bus.start = 1'b0;
        chk(tag, 32'(bus.err), 32'd1);
        chk("bad_busy", 32'(bus.busy), 32'd0);
        step();
        chk("err_pulse_end", 32'(bus.err), 32'd0);
    endtask
    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data_a = '0; bus.wr_data_b = '0;
        bus.start = 1'b0; bus.vec_len = '0; bus.signed_mode = 1'b0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_count", 32'(bus.res_count), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        // 1: unsigned length 4
        for (int i = 0; i < 4; i++) write_op(i, i + 1, 1);
        run("lat_len4", 4, 1'b0, 5);
        chk("done_high", 32'(bus.done), 32'd1);
        step();
        chk("done_pulse", 32'(bus.done), 32'd0);
        chk("count1", 32'(bus.res_count), 32'd1);
        rd_chk("res_t1", 0, 32'd10);
        step();
        chk("rd_hold", 32'(bus.rd_data), 32'd10);
        // 2: partial last beat
        for (int i = 0; i < 4; i++) write_op(i, 2 * (i + 1), i + 1);
        run("lat_len3", 3, 1'b0, 5);
        rd_chk("res_t2", 1, 32'd28);
        // 3: signed and unsigned on the same operands
        write_op(0, 8'hFF, 8'h03);
        write_op(1, 8'h02, 8'hFE);
        run("lat_len2s", 2, 1'b1, 4);
        rd_chk("res_signed", 2, 32'hFFFF9);
        run("lat_len2u", 2, 1'b0, 4);
        rd_chk("res_unsigned", 3, 32'd1273);
        // 4: full length, maximum magnitude
        for (int i = 0; i < 16; i++) write_op(i, 8'hFF, 8'hFF);
        run("lat_len16", 16, 1'b0, 11);
        rd_chk("res_max", 4, 32'hFE010);
        chk("count5", 32'(bus.res_count), 32'd5);
        // 5: illegal lengths, then start/wr_en while busy
        bad_len("err_len0", 0);
        bad_len("err_len17", 17);
        chk("count_after_err", 32'(bus.res_count), 32'd5);
        write_op(0, 1, 1);
        bus.start = 1'b1; bus.vec_len = 5'd2; bus.signed_mode = 1'b0;
        step();
        bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_data_a = 8'd0; bus.wr_data_b = 8'd0;
        bus.vec_len = 5'd1;
        step();
        bus.wr_en = 1'b0; bus.start = 1'b0;
        lat = 1;
        wait_done("lat_busy_ignore", 4);
        rd_chk("res_busy_ignore", 5, 32'd65026);
        run("lat_rerun", 2, 1'b0, 4);
        rd_chk("res_ram_kept", 6, 32'd65026);
        bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data_a = 8'd3; bus.wr_data_b = 8'd3;
        bus.start = 1'b1; bus.vec_len = 5'd1;
        step();
        bus.wr_en = 1'b0; bus.start = 1'b0;
        lat = 0;
        wait_done("lat_wr_start", 4);
        rd_chk("res_wr_start", 7, 32'd9);
        chk("count8", 32'(bus.res_count), 32'd8);
        // 6: fill and wrap the result RAM
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_count", 32'(bus.res_count), 32'd0);
        for (int i = 0; i < 16; i++) begin
            write_op(0, i + 1, 2);
            run("lat_fill", 1, 1'b0, 4);
        end
        chk("count_full", 32'(bus.res_count), 32'd16);
        rd_chk("res_fill0", 0, 32'd2);
        rd_chk("res_fill15", 15, 32'd32);
        write_op(0, 17, 2);
        bus.start = 1'b1; bus.vec_len = 5'd1;
        step();
        bus.start = 1'b0;
        step(); step(); step();
        bus.rd_en = 1'b1; bus.rd_addr = 4'd0;
        step();
        bus.rd_en = 1'b0;
        chk("done_17th", 32'(bus.done), 32'd1);
        chk("read_first", 32'(bus.rd_data), 32'd2);
        rd_chk("res_wrap0", 0, 32'd34);
        rd_chk("res_wrap1", 1, 32'd4);
        chk("count_sat", 32'(bus.res_count), 32'd16);
        // reset while fetching aborts the computation
        bus.start = 1'b1; bus.vec_len = 5'd16;
        step();
        bus.start = 1'b0;
        chk("busy_fetch", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_count", 32'(bus.res_count), 32'd0);
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.done) chk("abort_no_done", 32'(bus.done), 32'd0);
        end
        rd_chk("abort_ram0", 0, 32'd34);
        rd_chk("abort_ram1", 1, 32'd4);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
